// File: rtl/scr1_jal_tap_pkg.sv
// Shared definitions for the IMEM JAL tap: response codes, opcodes and the record layout.
// The jalr field of the record exists only when SCR1_JAL_TAP_JALR_EN is defined.
package scr1_jal_tap_pkg;

    localparam logic [1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_OK = 2'b01;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_ER = 2'b10;

    localparam logic [6:0] SCR1_OPC_JAL  = 7'b1101111;
    localparam logic [6:0] SCR1_OPC_JALR = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] target;
`ifdef SCR1_JAL_TAP_JALR_EN
        logic        jalr;
`endif
    } type_jal_rec_s;

    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] jal_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/scr1_jal_tap_fifo.sv
// Generic synchronous FIFO with first-word fall-through head; DEPTH must be at least 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module scr1_jal_tap_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-2 depths correct
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/scr1_imem_jal_tap.sv
// Passive IMEM monitor: pairs in-order responses with fetch addresses and queues JAL records.
// Define SCR1_JAL_TAP_JALR_EN to also record JALR fetches (target reported as 0).
module scr1_imem_jal_tap
    import scr1_jal_tap_pkg::*;
#(
    parameter int ADDRQ_DEPTH = 2,
    parameter int REC_DEPTH   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_req_ack,
    input  logic [31:0]      imem_addr,
    input  logic [1:0]       imem_resp,
    input  logic [31:0]      imem_rdata,
    output logic             rec_vd,
    input  logic             rec_rdy,
    output logic [31:0]      rec_pc,
    output logic [31:0]      rec_instr,
    output logic [31:0]      rec_target,
    output logic             rec_jalr,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             addrq_err
);

    logic          accept;
    logic          resp_any;
    logic          aq_pop;
    logic          aq_full;
    logic          aq_empty;
    logic [31:0]   aq_head;
    logic          is_jal;
    logic          is_match;
    logic          rec_push;
    logic          rec_pop;
    logic          rec_full;
    logic          rec_empty;
    logic          rec_drop;
    type_jal_rec_s rec_in;
    type_jal_rec_s rec_head;

    assign accept   = imem_req & imem_req_ack;
    assign resp_any = (imem_resp != SCR1_MEM_RESP_NOTRDY);
    assign aq_pop   = resp_any & ~aq_empty;

    scr1_jal_tap_fifo #(
        .WIDTH (32),
        .DEPTH (ADDRQ_DEPTH)
    ) i_addrq (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (imem_addr),
        .pop   (aq_pop),
        .rdata (aq_head),
        .full  (aq_full),
        .empty (aq_empty)
    );

    assign is_jal = (imem_rdata[6:0] == SCR1_OPC_JAL);

`ifdef SCR1_JAL_TAP_JALR_EN
    logic is_jalr;
    assign is_jalr  = (imem_rdata[6:0] == SCR1_OPC_JALR) & (imem_rdata[14:12] == 3'b000);
    assign is_match = is_jal | is_jalr;
`else
    assign is_match = is_jal;
`endif

    // Record contents come straight from the queue head and the response word
    always_comb begin
        rec_in        = '0;
        rec_in.pc     = aq_head;
        rec_in.instr  = imem_rdata;
        rec_in.target = is_jal ? (aq_head + jal_imm(imem_rdata)) : 32'h0;
`ifdef SCR1_JAL_TAP_JALR_EN
        rec_in.jalr   = is_jalr;
`endif
    end

    assign rec_push = (imem_resp == SCR1_MEM_RESP_RDY_OK) & ~aq_empty & is_match;
    assign rec_pop  = ~rec_empty & rec_rdy;
    assign rec_drop = rec_push & rec_full & ~rec_pop;

    scr1_jal_tap_fifo #(
        .WIDTH ($bits(type_jal_rec_s)),
        .DEPTH (REC_DEPTH)
    ) i_recq (
        .clk   (clk),
        .rst   (rst),
        .push  (rec_push),
        .wdata (rec_in),
        .pop   (rec_pop),
        .rdata (rec_head),
        .full  (rec_full),
        .empty (rec_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (rec_drop && !(&drop_cnt)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Sticky until reset: overflow of the address queue or an unmatched response
    always_ff @(posedge clk) begin
        if (rst) begin
            addrq_err <= 1'b0;
        end else if ((accept & aq_full & ~aq_pop) | (resp_any & aq_empty)) begin
            addrq_err <= 1'b1;
        end
    end

    assign rec_vd     = ~rec_empty;
    assign rec_pc     = rec_vd ? rec_head.pc     : 32'h0;
    assign rec_instr  = rec_vd ? rec_head.instr  : 32'h0;
    assign rec_target = rec_vd ? rec_head.target : 32'h0;
`ifdef SCR1_JAL_TAP_JALR_EN
    assign rec_jalr   = rec_vd & rec_head.jalr;
`else
    assign rec_jalr   = 1'b0;
`endif

endmodule

// File: tb/tb_scr1_imem_jal_tap.sv
// Directed self-checking bench for scr1_imem_jal_tap with a record scoreboard queue.
// JALR steps follow SCR1_JAL_TAP_JALR_EN.
module tb_scr1_imem_jal_tap;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic        imem_req_ack;
    logic [31:0] imem_addr;
    logic [1:0]  imem_resp;
    logic [31:0] imem_rdata;
    logic        rec_vd;
    logic        rec_rdy;
    logic [31:0] rec_pc;
    logic [31:0] rec_instr;
    logic [31:0] rec_target;
    logic        rec_jalr;
    logic [15:0] drop_cnt;
    logic        addrq_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] target;
        logic        jalr;
    } exp_rec_t;

    exp_rec_t expq[$];
    exp_rec_t dummy;
    int       vectors     = 0;
    int       miscompares = 0;
    int       exp_drop    = 0;

    localparam logic [31:0] JAL_P8 = 32'h0080006F;
    localparam logic [31:0] JAL_M8 = 32'hFF9FF06F;

    always #5 clk = ~clk;

    scr1_imem_jal_tap #(
        .ADDRQ_DEPTH (2),
        .REC_DEPTH   (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_req_ack (imem_req_ack),
        .imem_addr    (imem_addr),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .rec_vd       (rec_vd),
        .rec_rdy      (rec_rdy),
        .rec_pc       (rec_pc),
        .rec_instr    (rec_instr),
        .rec_target   (rec_target),
        .rec_jalr     (rec_jalr),
        .drop_cnt     (drop_cnt),
        .addrq_err    (addrq_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: optional accepted request plus a response code, then back to idle
    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic [1:0] resp, input logic [31:0] rdata);
        imem_req     = req;
        imem_req_ack = req;
        imem_addr    = addr;
        imem_resp    = resp;
        imem_rdata   = rdata;
        tick();
        imem_req     = 1'b0;
        imem_req_ack = 1'b0;
        imem_addr    = 32'h0;
        imem_resp    = 2'b00;
        imem_rdata   = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] target, input logic jalr);
        exp_rec_t r;
        r.pc     = pc;
        r.instr  = instr;
        r.target = target;
        r.jalr   = jalr;
        expq.push_back(r);
    endtask

    task automatic checkRecord(input string tag);
        checkOutput({tag, " vd"}, 32'(rec_vd), 32'd1);
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: record observed pc %h, none expected", tag, rec_pc);
        end else begin
            checkOutput({tag, " pc"},     rec_pc,           expq[0].pc);
            checkOutput({tag, " instr"},  rec_instr,        expq[0].instr);
            checkOutput({tag, " target"}, rec_target,       expq[0].target);
            checkOutput({tag, " jalr"},   32'(rec_jalr),    32'(expq[0].jalr));
        end
    endtask

    task automatic drainOne(input string tag);
        checkRecord(tag);
        rec_rdy = 1'b1;
        tick();
        rec_rdy = 1'b0;
        if (expq.size() > 0) dummy = expq.pop_front();
    endtask

    initial begin
        rst          = 1'b1;
        rec_rdy      = 1'b0;
        imem_req     = 1'b0;
        imem_req_ack = 1'b0;
        imem_addr    = 32'h0;
        imem_resp    = 2'b00;
        imem_rdata   = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset vd",     32'(rec_vd),    32'd0);
        checkOutput("reset pc",     rec_pc,         32'h0);
        checkOutput("reset instr",  rec_instr,      32'h0);
        checkOutput("reset target", rec_target,     32'h0);
        checkOutput("reset jalr",   32'(rec_jalr),  32'd0);
        checkOutput("reset drop",   32'(drop_cnt),  32'd0);
        checkOutput("reset err",    32'(addrq_err), 32'd0);

        // Positive JAL offset
        applyStimulus(1'b1, 32'h200, 2'b00, 32'h0);
        checkOutput("t1 vd before resp", 32'(rec_vd), 32'd0);
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        pushExp(32'h200, JAL_P8, 32'h208, 1'b0);
        drainOne("t1");
        checkOutput("t1 vd after drain", 32'(rec_vd), 32'd0);

        // Negative JAL offset
        applyStimulus(1'b1, 32'h100, 2'b00, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_M8);
        pushExp(32'h100, JAL_M8, 32'h0F8, 1'b0);
        drainOne("t2");

        // Non-JAL followed by JAL, in fetch order
        applyStimulus(1'b1, 32'h0, 2'b00, 32'h0);
        applyStimulus(1'b1, 32'h4, 2'b00, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b01, 32'h00000013);
        checkOutput("t3 addi no rec", 32'(rec_vd), 32'd0);
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        pushExp(32'h4, JAL_P8, 32'hC, 1'b0);
        drainOne("t3");
        checkOutput("t3 one rec", 32'(rec_vd), 32'd0);

        // Overflow of the record FIFO with the consumer stalled
        for (int i = 0; i < 6; i++) begin
            logic [31:0] pc;
            logic [31:0] ins;
            pc  = 32'h1000 + 32'(i * 4);
            ins = i[0] ? JAL_M8 : JAL_P8;
            applyStimulus(1'b1, pc, 2'b00, 32'h0);
            applyStimulus(1'b0, 32'h0, 2'b01, ins);
            if (expq.size() < 4) pushExp(pc, ins, i[0] ? pc - 32'd8 : pc + 32'd8, 1'b0);
            else exp_drop++;
        end
        checkOutput("t4 drop", 32'(drop_cnt), 32'(exp_drop));
        checkRecord("t4 head stable");

        // Full FIFO with a pop in the same cycle takes the new record
        applyStimulus(1'b1, 32'h2000, 2'b00, 32'h0);
        rec_rdy = 1'b1;
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        rec_rdy = 1'b0;
        dummy = expq.pop_front();
        pushExp(32'h2000, JAL_P8, 32'h2008, 1'b0);
        checkOutput("t4 no drop on pop", 32'(drop_cnt), 32'(exp_drop));
        for (int i = 0; i < 4; i++) drainOne("t4 drain");
        checkOutput("t4 empty", 32'(rec_vd), 32'd0);

        // Error response pops without recording; then an unmatched response
        applyStimulus(1'b1, 32'h300, 2'b00, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b10, 32'h0000006F);
        checkOutput("t5 er no rec", 32'(rec_vd), 32'd0);
        checkOutput("t5 er no err", 32'(addrq_err), 32'd0);
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        checkOutput("t5 empty resp err", 32'(addrq_err), 32'd1);
        checkOutput("t5 empty resp no rec", 32'(rec_vd), 32'd0);
        tick();
        checkOutput("t5 err sticky", 32'(addrq_err), 32'd1);

        // JALR handling depends on build configuration
        applyStimulus(1'b1, 32'h400, 2'b00, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'b01, 32'h00008067);
`ifdef SCR1_JAL_TAP_JALR_EN
        pushExp(32'h400, 32'h00008067, 32'h0, 1'b1);
        drainOne("t6 jalr");
`else
        checkOutput("t6 jalr ignored", 32'(rec_vd), 32'd0);
`endif

        // Reset with records and an address pending
        applyStimulus(1'b1, 32'h500, 2'b00, 32'h0);
        applyStimulus(1'b1, 32'h504, 2'b01, JAL_P8);
        applyStimulus(1'b1, 32'h508, 2'b01, JAL_P8);
        checkOutput("t6 two pending", 32'(rec_vd), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expq.delete();
        checkOutput("t6 rst vd",   32'(rec_vd),    32'd0);
        checkOutput("t6 rst pc",   rec_pc,         32'h0);
        checkOutput("t6 rst drop", 32'(drop_cnt),  32'd0);
        checkOutput("t6 rst err",  32'(addrq_err), 32'd0);
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        checkOutput("t6 stale resp err", 32'(addrq_err), 32'd1);
        checkOutput("t6 stale no rec",   32'(rec_vd),    32'd0);

        // Address-queue overflow drops the third address
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h600, 2'b00, 32'h0);
        applyStimulus(1'b1, 32'h604, 2'b00, 32'h0);
        checkOutput("t7 no overflow yet", 32'(addrq_err), 32'd0);
        applyStimulus(1'b1, 32'h608, 2'b00, 32'h0);
        checkOutput("t7 overflow err", 32'(addrq_err), 32'd1);
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        pushExp(32'h600, JAL_P8, 32'h608, 1'b0);
        drainOne("t7 first");
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_M8);
        pushExp(32'h604, JAL_M8, 32'h5FC, 1'b0);
        drainOne("t7 second");
        applyStimulus(1'b0, 32'h0, 2'b01, JAL_P8);
        checkOutput("t7 dropped addr", 32'(rec_vd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
